insertion_ctrl: RTL and testbench
=================================

# insertion_ctrl

Frame-level sequencer for the watermark insertion datapath. It walks a raster image pixel by pixel, reads each pixel's 2x2 neighbourhood from image memory and its 2-bit watermark symbol from watermark memory, and presents them to the insertion datapath. It waits out the datapath latency, then writes the watermarked pixel to output memory through a ready/enable handshake. It sits between the frame buffers and the insertion datapath, and is started once per frame by the top-level control.

## Interface
- `IMG_W`, default 256: image width in pixels, range 2..4096.
- `IMG_H`, default 256: image height in pixels, range 2..4096.
- `ADDR_W`, default 16: address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- `INS_LAT`, default 1: datapath latency in cycles, range 0..7.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the last pixel is written.
- `img_rd_en` out 1: image memory read strobe.
- `img_addr` out ADDR_W: image read address.
- `img_rdata` in 8: image read data, valid one cycle after `img_rd_en`.
- `wm_rd_en` out 1: watermark memory read strobe.
- `wm_addr` out ADDR_W: watermark read address.
- `wm_rdata` in 2: watermark symbol, valid one cycle after `wm_rd_en`.
- `dp_data1`..`dp_data4` out 8 each: neighbourhood pixels P(r,c), P(r,c+1), P(r+1,c), P(r+1,c+1).
- `dp_wm` out 2: watermark symbol to the datapath.
- `dp_valid` out 1: one-cycle pulse when the datapath inputs are launched.
- `dp_result` in 8: watermarked pixel from the datapath.
- `out_wr_en` out 1: output write request.
- `out_addr` out ADDR_W: output address, equal to r*IMG_W+c.
- `out_wdata` out 8: registered watermarked pixel.
- `out_ready` in 1: output memory accepts the write this cycle.

## Operation
- States are IDLE, FETCH, ISSUE, WAIT, WRITE and DONE.
- IDLE: `start`=1 loads r=c=0 and enters FETCH. `busy` rises on the following cycle.
- FETCH uses sub-counter k=0..4:
  - k=0..3 assert `img_rd_en` with the addresses of P(r,c), P(r,c+1), P(r+1,c), P(r+1,c+1) in that order.
  - k=0 also asserts `wm_rd_en` with `wm_addr`=r*IMG_W+c.
  - `img_rdata` is captured into `dp_data{k}` at k=1..4; `wm_rdata` is captured at k=1.
  - After k=4, go to ISSUE.
- ISSUE: `dp_valid`=1 for one cycle. Go to WAIT, or go straight to WRITE when INS_LAT=0.
- WAIT: counts INS_LAT cycles. `dp_data*` and `dp_wm` stay stable from ISSUE until the next FETCH.
- Result capture: `dp_result` is registered into `out_wdata` at the end of cycle ISSUE+INS_LAT.
- WRITE:
  - `out_wr_en`=1, with `out_addr` and `out_wdata` held stable until a cycle with `out_ready`=1.
  - On acceptance: advance c, or wrap to c=0 and increment r. Then go to FETCH, or go to DONE after pixel (IMG_H-1, IMG_W-1).
- DONE: `done`=1 for one cycle, `busy`=0 on the next cycle, return to IDLE.
- Address arithmetic:
  - Row base is kept in a running accumulator (+IMG_W per row); no multiplier.
  - Neighbour offsets are +1 and +IMG_W.
- Edge handling: see Configuration.
- `start` while not in IDLE is ignored.

## Timing
- Reset state: IDLE. All outputs are 0: `busy`, `done`, all strobes, all addresses, `dp_*`, `out_wdata`.
- Reset asserted mid-frame: on the next edge return to IDLE with all outputs at 0. The frame is abandoned and no partial write is completed.
- Per-pixel cycles with `out_ready` held high: 5 (FETCH) + 1 (ISSUE) + INS_LAT + 1 (WRITE) = 7+INS_LAT.
- Frame latency from `start` to `done`: 1 + IMG_W*IMG_H*(7+INS_LAT) cycles. Each cycle of `out_ready`=0 during WRITE adds one cycle.
- `done` and `out_wr_en` are never high in the same cycle.

## Configuration
- `INS_EDGE_CLAMP_EN` defined:
  - At c=IMG_W-1, the column c+1 is clamped to c. At r=IMG_H-1, the row r+1 is clamped to r.
  - Edge pixels are watermarked normally.
- `INS_EDGE_CLAMP_EN` undefined:
  - Edge pixels still perform all reads with clamped addresses.
  - `dp_wm` is forced to 2'b00, so the datapath passes P(r,c) through unmodified.
  - The watermark symbol read is consumed and discarded, so symbol indexing stays aligned with pixel index.

## Test plan
- IMG_W=IMG_H=4, INS_LAT=1, `out_ready`=1, `start` pulse:
  - First `img_addr` sequence is 0,1,4,5, with `wm_addr`=0.
  - `done` pulses at cycle 129 after `start`; 16 writes occur with `out_addr` 0..15 in order.
- Pixel (0,3) with macro defined: image addresses are 3,3,7,7. With the macro undefined, `dp_wm`=00 and `out_wdata` equals P(0,3).
- Pixel (3,3): image addresses are 15,15,15,15, followed by the final write to address 15 and a `done` pulse.
- Hold `out_ready`=0 for 3 cycles at pixel 5: `out_wr_en`, `out_addr`=5 and `out_wdata` stay stable for 4 cycles. The next FETCH issues address 6 on the cycle after acceptance.
- Reset mid-frame and a re-`start` during `busy`:
  - `rst_n`=0 during WAIT of pixel 7 gives all outputs 0 on the next cycle, and IDLE.
  - A `start` asserted while `busy`=1 has no effect on the address sequence.
- INS_LAT=0 with a combinational datapath model: per-pixel period is 7 cycles, and `out_wdata` matches the model at the ISSUE cycle.

Source files
------------

// File: rtl/insertion_ctrl.sv
// insertion_ctrl: walks the frame pixel by pixel, fetches each 2x2 neighbourhood plus its watermark
// symbol, launches the insertion datapath and writes the result. Define INS_EDGE_CLAMP_EN to watermark edge pixels.
module insertion_ctrl #(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int ADDR_W  = 16,
    parameter int INS_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              img_rd_en,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [7:0]        img_rdata,
    output logic              wm_rd_en,
    output logic [ADDR_W-1:0] wm_addr,
    input  logic [1:0]        wm_rdata,
    output logic [7:0]        dp_data1,
    output logic [7:0]        dp_data2,
    output logic [7:0]        dp_data3,
    output logic [7:0]        dp_data4,
    output logic [1:0]        dp_wm,
    output logic              dp_valid,
    input  logic [7:0]        dp_result,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_wdata,
    input  logic              out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [12:0]       LAST_COL  = 13'(IMG_W - 1);
    localparam logic [12:0]       LAST_ROW  = 13'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [2:0]        LAST_WAIT = 3'((INS_LAT > 0) ? INS_LAT - 1 : 0);

    state_t            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        wait_q, wait_d;
    logic [12:0]       col_q, col_d;
    logic [12:0]       row_q, row_d;
    logic [ADDR_W-1:0] rowBase_q, rowBase_d;
    logic [7:0]        data1_q, data1_d;
    logic [7:0]        data2_q, data2_d;
    logic [7:0]        data3_q, data3_d;
    logic [7:0]        data4_q, data4_d;
    logic [1:0]        wm_q, wm_d;
    logic [7:0]        wdata_q, wdata_d;

    logic              lastCol, lastRow;
    logic [ADDR_W-1:0] pixAddr, colOff, rowOff;
    logic [1:0]        wmSym;

    // Neighbour offsets collapse to zero on the last column/row so edge reads stay inside the frame.
    assign lastCol = (col_q == LAST_COL);
    assign lastRow = (row_q == LAST_ROW);
    assign pixAddr = rowBase_q + ADDR_W'(col_q);
    assign colOff  = lastCol ? '0 : ADDR_W'(1);
    assign rowOff  = lastRow ? '0 : ROW_STEP;

`ifdef INS_EDGE_CLAMP_EN
    assign wmSym = wm_rdata;
`else
    logic edgePix;
    assign edgePix = lastCol | lastRow;
    assign wmSym   = edgePix ? 2'b00 : wm_rdata;
`endif

    assign dp_data1  = data1_q;
    assign dp_data2  = data2_q;
    assign dp_data3  = data3_q;
    assign dp_data4  = data4_q;
    assign dp_wm     = wm_q;
    assign out_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            wait_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            rowBase_q <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            data3_q   <= '0;
            data4_q   <= '0;
            wm_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            wait_q    <= wait_d;
            col_q     <= col_d;
            row_q     <= row_d;
            rowBase_q <= rowBase_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            data3_q   <= data3_d;
            data4_q   <= data4_d;
            wm_q      <= wm_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        wait_d    = wait_q;
        col_d     = col_q;
        row_d     = row_q;
        rowBase_d = rowBase_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        data3_d   = data3_q;
        data4_d   = data4_q;
        wm_d      = wm_q;
        wdata_d   = wdata_q;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        img_rd_en = 1'b0;
        img_addr  = '0;
        wm_rd_en  = 1'b0;
        wm_addr   = '0;
        dp_valid  = 1'b0;
        out_wr_en = 1'b0;
        out_addr  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    k_d       = '0;
                    col_d     = '0;
                    row_d     = '0;
                    rowBase_d = '0;
                end
            end
            // Each read's data arrives one step later, so capture trails the address by one k.
            S_FETCH: begin
                k_d = k_q + 3'd1;
                case (k_q)
                    3'd0: begin
                        img_rd_en = 1'b1;
                        img_addr  = pixAddr;
                        wm_rd_en  = 1'b1;
                        wm_addr   = pixAddr;
                    end
                    3'd1: begin
                        img_rd_en = 1'b1;
                        img_addr  = pixAddr + colOff;
                        data1_d   = img_rdata;
                        wm_d      = wmSym;
                    end
                    3'd2: begin
                        img_rd_en = 1'b1;
                        img_addr  = pixAddr + rowOff;
                        data2_d   = img_rdata;
                    end
                    3'd3: begin
                        img_rd_en = 1'b1;
                        img_addr  = pixAddr + rowOff + colOff;
                        data3_d   = img_rdata;
                    end
                    default: begin
                        data4_d = img_rdata;
                        k_d     = '0;
                        state_d = S_ISSUE;
                    end
                endcase
            end
            S_ISSUE: begin
                dp_valid = 1'b1;
                if (INS_LAT == 0) begin
                    wdata_d = dp_result;
                    state_d = S_WRITE;
                end else begin
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    wdata_d = dp_result;
                    state_d = S_WRITE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_WRITE: begin
                out_wr_en = 1'b1;
                out_addr  = pixAddr;
                if (out_ready) begin
                    k_d = '0;
                    if (lastCol) begin
                        col_d     = '0;
                        row_d     = row_q + 13'd1;
                        rowBase_d = rowBase_q + ROW_STEP;
                    end else begin
                        col_d = col_q + 13'd1;
                    end
                    state_d = (lastCol && lastRow) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_insertion_ctrl.sv
// Bench for insertion_ctrl: two 4x4 instances (datapath latency 1 and 0) checked cycle by cycle
// against a pixel-level reference model with random frame contents and out_ready stalls.
module tb_insertion_ctrl;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int AW   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstN      [2];
    logic          start     [2];
    logic          busy      [2];
    logic          done      [2];
    logic          imgRdEn   [2];
    logic [AW-1:0] imgAddr   [2];
    logic [7:0]    imgRdata  [2];
    logic          wmRdEn    [2];
    logic [AW-1:0] wmAddr    [2];
    logic [1:0]    wmRdata   [2];
    logic [7:0]    dpData1   [2];
    logic [7:0]    dpData2   [2];
    logic [7:0]    dpData3   [2];
    logic [7:0]    dpData4   [2];
    logic [1:0]    dpWm      [2];
    logic          dpValid   [2];
    logic [7:0]    dpResult  [2];
    logic          outWrEn   [2];
    logic [AW-1:0] outAddr   [2];
    logic [7:0]    outWdata  [2];
    logic          outReady  [2];

    insertion_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .INS_LAT(1)) dutA (
        .clk(clk), .rst_n(rstN[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .img_rd_en(imgRdEn[0]), .img_addr(imgAddr[0]), .img_rdata(imgRdata[0]),
        .wm_rd_en(wmRdEn[0]), .wm_addr(wmAddr[0]), .wm_rdata(wmRdata[0]),
        .dp_data1(dpData1[0]), .dp_data2(dpData2[0]), .dp_data3(dpData3[0]), .dp_data4(dpData4[0]),
        .dp_wm(dpWm[0]), .dp_valid(dpValid[0]), .dp_result(dpResult[0]),
        .out_wr_en(outWrEn[0]), .out_addr(outAddr[0]), .out_wdata(outWdata[0]), .out_ready(outReady[0])
    );

    insertion_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .INS_LAT(0)) dutB (
        .clk(clk), .rst_n(rstN[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .img_rd_en(imgRdEn[1]), .img_addr(imgAddr[1]), .img_rdata(imgRdata[1]),
        .wm_rd_en(wmRdEn[1]), .wm_addr(wmAddr[1]), .wm_rdata(wmRdata[1]),
        .dp_data1(dpData1[1]), .dp_data2(dpData2[1]), .dp_data3(dpData3[1]), .dp_data4(dpData4[1]),
        .dp_wm(dpWm[1]), .dp_valid(dpValid[1]), .dp_result(dpResult[1]),
        .out_wr_en(outWrEn[1]), .out_addr(outAddr[1]), .out_wdata(outWdata[1]), .out_ready(outReady[1])
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] img   [2][NPIX];
    logic [1:0] wmMem [2][NPIX];

    bit            active      [2];
    bit            inWrite     [2];
    bit            expectFetch [2];
    bit            prevImgRd   [2];
    bit            prevWmRd    [2];
    logic [AW-1:0] prevImgAddr [2];
    logic [AW-1:0] prevWmAddr  [2];
    int            cyc         [2];
    int            readIdx     [2];
    int            wmIdx       [2];
    int            issueIdx    [2];
    int            wrIdx       [2];
    int            lastAcc     [2];
    int            pixStalls   [2];
    int            totalStalls [2];
    int            resDue      [2];
    int            holdCnt     [2];
    int            readyMode   [2];

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // Address of neighbour j (0..3) of pixel p, with the column/row clamped at the frame edge.
    function automatic int nbAddr(input int p, input int j);
        int r = p / W;
        int c = p % W;
        int rr = (j >= 2 && r < H - 1) ? r + 1 : r;
        int cc = (j % 2 == 1 && c < W - 1) ? c + 1 : c;
        return rr * W + cc;
    endfunction

    function automatic int expAddr(input int idx);
        if (idx >= 4 * NPIX) return 32'h0000FFFF;
        return nbAddr(idx / 4, idx % 4);
    endfunction

    function automatic logic [7:0] expPix(input int d, input int p, input int j);
        return img[d][nbAddr(p, j)];
    endfunction

    function automatic logic [1:0] expWm(input int d, input int p);
        bit edgePix = ((p / W) == H - 1) || ((p % W) == W - 1);
`ifdef INS_EDGE_CLAMP_EN
        if (edgePix) return wmMem[d][p];
        return wmMem[d][p];
`else
        return edgePix ? 2'b00 : wmMem[d][p];
`endif
    endfunction

    // Datapath stand-in: symbol 00 passes P(r,c) through untouched.
    function automatic logic [7:0] dpModel(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] e,
                                           input logic [1:0] w);
        return a ^ ({4{w}} & (b | c | e));
    endfunction

    function automatic logic [7:0] expRes(input int d, input int p);
        if (p >= NPIX) return 8'h00;
        return dpModel(expPix(d, p, 0), expPix(d, p, 1), expPix(d, p, 2), expPix(d, p, 3), expWm(d, p));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input int d);
        checkOutput($sformatf("rstBusy%0d", d),    busy[d],     0);
        checkOutput($sformatf("rstDone%0d", d),    done[d],     0);
        checkOutput($sformatf("rstImgEn%0d", d),   imgRdEn[d],  0);
        checkOutput($sformatf("rstWmEn%0d", d),    wmRdEn[d],   0);
        checkOutput($sformatf("rstDpValid%0d", d), dpValid[d],  0);
        checkOutput($sformatf("rstWrEn%0d", d),    outWrEn[d],  0);
        checkOutput($sformatf("rstImgAddr%0d", d), imgAddr[d],  0);
        checkOutput($sformatf("rstWmAddr%0d", d),  wmAddr[d],   0);
        checkOutput($sformatf("rstOutAddr%0d", d), outAddr[d],  0);
        checkOutput($sformatf("rstData%0d", d),    {dpData1[d], dpData2[d], dpData3[d], dpData4[d]}, 0);
        checkOutput($sformatf("rstDpWm%0d", d),    dpWm[d],     0);
        checkOutput($sformatf("rstWdata%0d", d),   outWdata[d], 0);
    endtask

    task automatic beginFrame(input int d);
        for (int i = 0; i < NPIX; i++) begin
            img[d][i]   = 8'($urandom);
            wmMem[d][i] = 2'($urandom_range(0, 3));
        end
        cyc[d] = 0; readIdx[d] = 0; wmIdx[d] = 0; issueIdx[d] = 0; wrIdx[d] = 0;
        lastAcc[d] = 0; pixStalls[d] = 0; totalStalls[d] = 0; resDue[d] = -1; holdCnt[d] = 0;
        inWrite[d] = 1'b0; expectFetch[d] = 1'b0; active[d] = 1'b1;
        start[d] = 1'b1;
    endtask

    // One clock cycle: memory/datapath responses, checks of the current cycle, then the edge.
    task automatic applyStimulus();
        for (int d = 0; d < 2; d++) begin
            logic ready;
            int   p;
            imgRdata[d] = (prevImgRd[d] && int'(prevImgAddr[d]) < NPIX) ? img[d][int'(prevImgAddr[d])] : 8'($urandom);
            wmRdata[d]  = (prevWmRd[d] && int'(prevWmAddr[d]) < NPIX) ? wmMem[d][int'(prevWmAddr[d])] : 2'($urandom);
            prevImgRd[d]   = imgRdEn[d];
            prevImgAddr[d] = imgAddr[d];
            prevWmRd[d]    = wmRdEn[d];
            prevWmAddr[d]  = wmAddr[d];
            ready = (readyMode[d] == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!active[d]) begin
                checkOutput($sformatf("idle%0d", d),
                            {26'd0, busy[d], done[d], imgRdEn[d], wmRdEn[d], dpValid[d], outWrEn[d]}, 0);
                dpResult[d] = 8'($urandom);
            end else begin
                if (cyc[d] == 0) checkOutput($sformatf("busyAtStart%0d", d), busy[d], 0);
                if (cyc[d] == 1) checkOutput($sformatf("busyRise%0d", d), busy[d], 1);
                if (expectFetch[d]) begin
                    checkOutput($sformatf("fetchAfterAccept%0d", d), imgRdEn[d], 1);
                    expectFetch[d] = 1'b0;
                end
                if (imgRdEn[d]) begin
                    checkOutput($sformatf("imgAddr%0d_%0d", d, readIdx[d]), imgAddr[d], expAddr(readIdx[d]));
                    readIdx[d]++;
                end
                if (wmRdEn[d]) begin
                    checkOutput($sformatf("wmAddr%0d_%0d", d, wmIdx[d]), wmAddr[d], wmIdx[d]);
                    wmIdx[d]++;
                end
                if (dpValid[d]) begin
                    p = issueIdx[d];
                    checkOutput($sformatf("dpData1_%0d_%0d", d, p), dpData1[d], (p < NPIX) ? expPix(d, p, 0) : 8'h00);
                    checkOutput($sformatf("dpData2_%0d_%0d", d, p), dpData2[d], (p < NPIX) ? expPix(d, p, 1) : 8'h00);
                    checkOutput($sformatf("dpData3_%0d_%0d", d, p), dpData3[d], (p < NPIX) ? expPix(d, p, 2) : 8'h00);
                    checkOutput($sformatf("dpData4_%0d_%0d", d, p), dpData4[d], (p < NPIX) ? expPix(d, p, 3) : 8'h00);
                    checkOutput($sformatf("dpWm%0d_%0d", d, p),     dpWm[d],    (p < NPIX) ? expWm(d, p) : 2'b00);
                    resDue[d] = cyc[d] + latOf(d);
                    issueIdx[d]++;
                end
                dpResult[d] = (cyc[d] == resDue[d])
                              ? dpModel(dpData1[d], dpData2[d], dpData3[d], dpData4[d], dpWm[d])
                              : 8'($urandom);
                if (outWrEn[d]) begin
                    if (!inWrite[d]) begin
                        inWrite[d] = 1'b1;
                        if (readyMode[d] == 1 && wrIdx[d] == 5) holdCnt[d] = 3;
                    end
                    checkOutput($sformatf("outAddr%0d_%0d", d, wrIdx[d]), outAddr[d], wrIdx[d]);
                    checkOutput($sformatf("outWdata%0d_%0d", d, wrIdx[d]), outWdata[d], expRes(d, wrIdx[d]));
                    if (holdCnt[d] > 0) begin
                        ready = 1'b0;
                        holdCnt[d]--;
                    end
                    if (ready) begin
                        checkOutput($sformatf("pixelPeriod%0d_%0d", d, wrIdx[d]),
                                    cyc[d] - lastAcc[d], 7 + latOf(d) + pixStalls[d]);
                        lastAcc[d]   = cyc[d];
                        pixStalls[d] = 0;
                        inWrite[d]   = 1'b0;
                        wrIdx[d]++;
                        if (wrIdx[d] < NPIX) expectFetch[d] = 1'b1;
                    end else begin
                        pixStalls[d]++;
                        totalStalls[d]++;
                    end
                end
                if (done[d] || outWrEn[d])
                    checkOutput($sformatf("doneWithWrite%0d", d), done[d] & outWrEn[d], 0);
                if (done[d]) begin
                    checkOutput($sformatf("doneCycle%0d", d), cyc[d], 1 + NPIX * (7 + latOf(d)) + totalStalls[d]);
                    checkOutput($sformatf("writeCount%0d", d), wrIdx[d], NPIX);
                    checkOutput($sformatf("busyAtDone%0d", d), busy[d], 1);
                    active[d] = 1'b0;
                end
            end
            outReady[d] = ready;
        end
        @(posedge clk);
        #1;
        cyc[0]++;
        cyc[1]++;
    endtask

    task automatic waitFrame(input int d, input int budget);
        int n = 0;
        while (active[d] && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput($sformatf("frameFinished%0d", d), active[d], 0);
        active[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstN[d] = 1'b0; start[d] = 1'b0; outReady[d] = 1'b1; dpResult[d] = 8'h00;
            imgRdata[d] = 8'h00; wmRdata[d] = 2'b00; active[d] = 1'b0; readyMode[d] = 0;
            prevImgRd[d] = 1'b0; prevWmRd[d] = 1'b0; prevImgAddr[d] = '0; prevWmAddr[d] = '0;
            cyc[d] = 0; resDue[d] = -1; holdCnt[d] = 0;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkResetState(0);
        checkResetState(1);
        rstN[0] = 1'b1;
        rstN[1] = 1'b1;
        repeat (2) applyStimulus();

        // Frame 1: three-cycle out_ready stall on pixel 5 and a stray start while busy.
        readyMode[0] = 1;
        beginFrame(0);
        applyStimulus();
        start[0] = 1'b0;
        repeat (20) applyStimulus();
        start[0] = 1'b1;
        applyStimulus();
        start[0] = 1'b0;
        waitFrame(0, 400);
        repeat (2) applyStimulus();

        // Frame 2: reset lands in the WAIT cycle of pixel 7.
        readyMode[0] = 0;
        beginFrame(0);
        applyStimulus();
        start[0] = 1'b0;
        for (int n = 0; n < 400 && issueIdx[0] < 8; n++) applyStimulus();
        checkOutput("reachPixel7", issueIdx[0], 8);
        rstN[0] = 1'b0;
        applyStimulus();
        active[0] = 1'b0;
        checkResetState(0);
        rstN[0] = 1'b1;
        repeat (4) applyStimulus();

        // Frame 3: random out_ready throughout.
        readyMode[0] = 2;
        beginFrame(0);
        applyStimulus();
        start[0] = 1'b0;
        waitFrame(0, 1500);
        repeat (2) applyStimulus();

        // Frames 4 and 5: zero-latency datapath, ready held high then random.
        readyMode[1] = 0;
        beginFrame(1);
        applyStimulus();
        start[1] = 1'b0;
        waitFrame(1, 400);
        repeat (2) applyStimulus();
        readyMode[1] = 2;
        beginFrame(1);
        applyStimulus();
        start[1] = 1'b0;
        waitFrame(1, 1500);
        repeat (2) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
